muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the execute stage, owning the HI/LO register pair. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the EX stage and returns 64-bit products or quotient/remainder pairs after a fixed latency. While it is busy, the hazard unit stalls any MFHI/MFLO or new mul/div request. HI/LO are read directly by the EX-stage result mux.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — request valid; sampled only when `busy`=0.
- `op`  in  3  — 3'd0 MULT, 3'd1 MULTU, 3'd2 DIV, 3'd3 DIVU, 3'd4 MTHI, 3'd5 MTLO, others no-op.
- `a`  in  32  — rs operand: multiplicand / dividend / MTHI-MTLO data.
- `b`  in  32  — rt operand: multiplier / divisor.
- `busy`  out  1  — operation in progress.
- `done`  out  1  — one-cycle pulse; HI/LO hold the new result.
- `hi`  out  32  — HI register.
- `lo`  out  32  — LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: 32 iteration cycles; 5-bit counter.
  - FIX: sign correction and HI/LO write.
- IDLE with `start`=1:
  - op 0–3: latch operand magnitudes (absolute values for the signed ops), result sign, remainder sign and op; clear the 64-bit accumulator; go to RUN.
  - op 4: `hi`←`a`, stay in IDLE.
  - op 5: `lo`←`a`, stay in IDLE.
  - Any other op: no state change.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first.
- RUN exit: after 32 iterations (counter 31→0), go to FIX.
- FIX:
  - Multiply: {`hi`,`lo`} ← product, two's-complement negated if the result sign is set.
  - Divide: `lo` ← quotient, negated if sign(a)≠sign(b) for DIV; `hi` ← remainder, carrying the sign of the dividend for DIV.
  - Assert `done`, return to IDLE.
- Divide by zero (`b`=0): full latency; `hi`=`a` (unmodified dividend), `lo`=32'hFFFF_FFFF for DIVU; for DIV, `lo`=32'h0000_0001 if a<0, else 32'hFFFF_FFFF. This is the natural output of the restoring algorithm plus sign fix.
- DIV 0x8000_0000 / −1: `lo`=0x8000_0000, `hi`=0. No trap.
- `start` while `busy`=1 is ignored. The hazard unit must not issue it.
- HI/LO change only at FIX, on MTHI/MTLO, or on reset.

## Timing
- Reset: state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0, all internal registers 0.
- Request accepted at edge E0 (`start`=1, `busy`=0).
- Mul/div sequence:
  - `busy`=1 from after E0 through E33.
  - Iterations occur on edges E1..E32.
  - FIX on edge E33 writes HI/LO; `done`=1 and `busy`=0 for the cycle after E33.
  - Total: 33-cycle busy window, result visible 34 cycles after the request cycle.
- A new `start` may be accepted at E34, i.e. the edge ending the `done` cycle.
- MTHI/MTLO: write visible the cycle after E0; `busy` and `done` stay 0.
- `rst_n` low mid-operation: immediately abort to reset values; no `done`.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined:
    - MULT/MULTU compute with a single-cycle 32×32 multiplier.
    - At E0, {`hi`,`lo`} ← product; `done`=1 for the cycle after E0; `busy` never asserts for multiplies.
    - Divides are unchanged.
  - Undefined: multiplies use the iterative 34-cycle path above. No hardware multiplier is inferred.

## Test plan
- Reset then idle: `hi`=`lo`=0, `busy`=`done`=0. Pulse `rst_n` low at RUN cycle 10 of a DIV → all outputs 0 immediately, and no `done` ever follows.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` 34 cycles after request; `hi`=0xFFFF_FFFE, `lo`=0x0000_0001. MULT with the same operands → `hi`=0, `lo`=1. With `MULDIV_FAST_MUL_EN` defined → same results, `done` the cycle after request, `busy` never asserts.
- DIV a=−7 (0xFFFF_FFF9), b=2 → `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1). DIVU a=100, b=7 → `lo`=14, `hi`=2.
- DIVU a=0x1234, b=0 → `hi`=0x1234, `lo`=0xFFFF_FFFF. DIV a=0x8000_0000, b=0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- MTHI a=0xDEAD_BEEF then MTLO a=0x1 on consecutive cycles → `hi`/`lo` updated the next cycle each, `done` stays 0. During a DIV, `start` with op=MTLO is ignored; `lo` afterwards is the quotient.
- Back-to-back: a second request held on `start` through the `done` cycle is accepted at E34; its `done` follows 34 cycles later. `busy` drops for exactly one cycle between the two.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO pair (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state, nstate;
   logic [4:0]  cnt;
   logic [31:0] mcand;    // multiplicand or divisor magnitude
   logic [31:0] mq;       // multiplier (shifts right) or dividend (shifts left)
   logic [63:0] acc;
   logic        isdiv, rsign, remsign;

   logic        sgn_op, go_iter;
   logic [31:0] amag, bmag;
   logic [32:0] msum, rsh;
   logic [31:0] rdiff;
   logic        ge;

   assign sgn_op = ~op[0];
   assign amag   = (sgn_op && a[31]) ? -a : a;
   assign bmag   = (sgn_op && b[31]) ? -b : b;
`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fprod;
   assign go_iter = ~op[2] & op[1];
   assign fprod   = {{32{sgn_op & a[31]}}, a} * {{32{sgn_op & b[31]}}, b};
`else
   assign go_iter = ~op[2];
`endif

   assign msum  = {1'b0, acc[63:32]} + {1'b0, (mq[0] ? mcand : 32'd0)};
   // Partial remainder never exceeds the divisor, so the low 32 bits of the difference are exact.
   assign rsh   = {acc[63:32], mq[31]};
   assign ge    = (rsh >= {1'b0, mcand});
   assign rdiff = rsh[31:0] - mcand;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start && go_iter) nstate = RUN;
         RUN:     if (cnt == 5'd0) nstate = FIX;
         FIX:     nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         mcand   <= '0;
         mq      <= '0;
         acc     <= '0;
         isdiv   <= 1'b0;
         rsign   <= 1'b0;
         remsign <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (go_iter) begin
                  mcand   <= bmag;
                  mq      <= amag;
                  acc     <= '0;
                  cnt     <= 5'd31;
                  isdiv   <= op[1];
                  rsign   <= sgn_op & (a[31] ^ b[31]);
                  remsign <= sgn_op & op[1] & a[31];
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!op[2]) begin
                  {hi, lo} <= fprod;
                  done     <= 1'b1;
               end
`endif
               else if (op == 3'd4) hi <= a;
               else if (op == 3'd5) lo <= a;
            end
            RUN: begin
               cnt <= cnt - 5'd1;
               if (isdiv) begin
                  acc <= {(ge ? rdiff : rsh[31:0]), acc[30:0], ge};
                  mq  <= {mq[30:0], 1'b0};
               end else begin
                  acc <= {msum, acc[31:1]};
                  mq  <= {1'b0, mq[31:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (isdiv) begin
                  lo <= rsign   ? -acc[31:0]  : acc[31:0];
                  hi <= remsign ? -acc[63:32] : acc[63:32];
               end else begin
                  {hi, lo} <= rsign ? -acc : acc;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   muldiv_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l);
      int sx, sy;
      logic [63:0] p;
      sx = x; sy = y; h = '0; l = '0;
      case (o)
         3'd0: begin p = 64'(longint'(sx) * longint'(sy)); {h, l} = p; end
         3'd1: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; end
         3'd2: if (y == 0) begin h = x; l = (sx < 0) ? 32'd1 : 32'hFFFF_FFFF; end
               else if (x == 32'h8000_0000 && sy == -1) begin l = x; h = 0; end
               else begin l = 32'(sx / sy); h = 32'(sx % sy); end
         3'd3: if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
               else begin l = x / y; h = x % y; end
         default: ;
      endcase
   endfunction

   task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] eh, el;
      int lat, bz, elat, ebz;
      model(o, x, y, eh, el);
      elat = (FAST && !o[1]) ? 1 : 34;
      ebz  = (FAST && !o[1]) ? 0 : 33;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bz = 0;
      while (!done && lat < 60) begin
         if (busy) bz++;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(elat));
      chk({tag, "_busy"}, 64'(bz), 64'(ebz));
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      logic [31:0] eh, el;
      int seen, lat;
      #12 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);

      // directed vectors
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1");
      run(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7");
      run(3'd3, 32'd100, 32'd7, "divu_100");
      run(3'd3, 32'h1234, 32'd0, "divu_z");
      run(3'd2, 32'h8000_0005, 32'd0, "div_negz");
      run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min");

      // MTHI then MTLO on consecutive cycles
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      chk("mthi_done", 64'({busy, done}), 64'd0);
      op = 3'd5; a = 32'h1;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h1);
      chk("mtlo_done", 64'({busy, done}), 64'd0);

      // MTLO issued while a DIV is running must be ignored
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; op = 3'd5; a = 32'h55;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_ign_now", 64'(lo), 64'h1);
      lat = 0;
      while (!done && lat < 60) begin @(negedge clk); lat++; end
      chk("mtlo_ign_done", 64'(done), 64'd1);
      chk("mtlo_ign_lo", 64'(lo), 64'd14);
      chk("mtlo_ign_hi", 64'(hi), 64'd2);

      // back-to-back: second request held on start through the done cycle
      @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk);
      lat = 1;
      while (!done && lat < 60) begin @(negedge clk); lat++; end
      chk("b2b1_lat", 64'(lat), 64'd34);
      chk("b2b1_lo", 64'(lo), 64'd14);
      chk("b2b_gap_busy", 64'(busy), 64'd0);
      op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_reaccept", 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 60) begin @(negedge clk); lat++; end
      chk("b2b2_lat", 64'(lat), 64'd34);
      chk("b2b2_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("b2b2_hi", 64'(hi), 64'hFFFF_FFFF);

      // randomized mul/div against the model
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         else if ($urandom_range(0, 1) == 1) rb = $urandom;
         else rb = 32'($urandom_range(1, 50));
         run(ro, ra, rb, "rnd");
      end

      // reset mid-divide: outputs clear at once, no done afterwards
      @(negedge clk);
      start = 1'b1; op = 3'd4; a = 32'hCAFE_0001;
      @(negedge clk);
      op = 3'd2; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_bd", 64'({busy, done}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin @(negedge clk); if (done || busy) seen++; end
      chk("abort_nodone", 64'(seen), 64'd0);

      model(3'd1, 32'd3, 32'd5, eh, el);
      run(3'd1, 32'd3, 32'd5, "post_rst");
      chk("post_rst_model", {eh, el}, 64'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
